// File: rtl/gift_g_layer_3share.sv
// rtl/gift_g_layer_3share.sv - 3-share masked GIFT G layer over NSBOX nibbles, valid/ready pipelined.
// Component functions are split by share pairs so no fresh randomness is consumed.

module NF_CF_2 (
    input  logic [2:0]  a_i,
    input  logic [2:0]  b_i,
    input  logic [2:0]  c_i,
    input  logic [2:0]  d_i,
    output logic [26:0] cf_o
);
    // Block 0: a ^ b&c, block 1: b ^ a&d, block 2: c ^ a&b.
    // Output share k owns the cross terms (k, (k+m)%3) for m = 0..2, plus linear share k.
    for (genvar k = 0; k < 3; k++) begin : g_k
        for (genvar m = 0; m < 3; m++) begin : g_m
            localparam int Q = (k + m) % 3;
            if (m == 0) begin : g_lin
                assign cf_o[3*k+m]    = a_i[k] ^ (b_i[k] & c_i[Q]);
                assign cf_o[9+3*k+m]  = b_i[k] ^ (a_i[k] & d_i[Q]);
                assign cf_o[18+3*k+m] = c_i[k] ^ (a_i[k] & b_i[Q]);
            end else begin : g_quad
                assign cf_o[3*k+m]    = b_i[k] & c_i[Q];
                assign cf_o[9+3*k+m]  = a_i[k] & d_i[Q];
                assign cf_o[18+3*k+m] = a_i[k] & b_i[Q];
            end
        end
    end
endmodule

module gift_g_layer_3share #(
    parameter int NSBOX   = 16,
    parameter int OUT_REG = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NSBOX-1:0]   in1,
    input  logic [4*NSBOX-1:0]   in2,
    input  logic [4*NSBOX-1:0]   in3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NSBOX-1:0]   out1,
    output logic [4*NSBOX-1:0]   out2,
    output logic [4*NSBOX-1:0]   out3
);
    logic [27*NSBOX-1:0]          cf_d, cf_q;
    logic [3*NSBOX-1:0]           lin_d, lin_q;
    logic                         v1_q;
    logic                         adv1;
    logic [2:0][4*NSBOX-1:0]      cmp;

    for (genvar i = 0; i < NSBOX; i++) begin : g_slice
        NF_CF_2 u_cf (
            .a_i  ({in3[4*i],   in2[4*i],   in1[4*i]}),
            .b_i  ({in3[4*i+1], in2[4*i+1], in1[4*i+1]}),
            .c_i  ({in3[4*i+2], in2[4*i+2], in1[4*i+2]}),
            .d_i  ({in3[4*i+3], in2[4*i+3], in1[4*i+3]}),
            .cf_o (cf_d[27*i +: 27])
        );
        assign lin_d[3*i +: 3] = {in3[4*i+3], in2[4*i+3], in1[4*i+3]};

        // Compression reads registers only; bit1 stays a share-wise wire.
        for (genvar j = 0; j < 3; j++) begin : g_share
            assign cmp[j][4*i]   = ^cf_q[27*i + 3*j +: 3];
            assign cmp[j][4*i+1] = lin_q[3*i + j];
            assign cmp[j][4*i+2] = ^cf_q[27*i + 9 + 3*j +: 3];
            assign cmp[j][4*i+3] = ^cf_q[27*i + 18 + 3*j +: 3];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            cf_q  <= '0;
            lin_q <= '0;
        end else if (adv1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                cf_q  <= cf_d;
                lin_q <= lin_d;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic                    v2_q;
        logic [2:0][4*NSBOX-1:0] s2_q;
        logic                    adv2;

        assign adv2 = !v2_q || out_ready;
        assign adv1 = !v1_q || adv2;

        always_ff @(posedge clk) begin
            if (rst) begin
                v2_q <= 1'b0;
                s2_q <= '0;
            end else if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    s2_q <= cmp;
                end
            end
        end

        assign out_valid = v2_q;
        assign out1      = s2_q[0];
        assign out2      = s2_q[1];
        assign out3      = s2_q[2];
    end else begin : g_ocomb
        assign adv1      = !v1_q || out_ready;
        assign out_valid = v1_q;
        assign out1      = cmp[0];
        assign out2      = cmp[1];
        assign out3      = cmp[2];
    end

    assign in_ready = adv1;
endmodule

// File: tb/tb_gift_g_layer_3share.sv
// tb/tb_gift_g_layer_3share.sv - randomized self-checking bench against a G lookup-table model.

module tb_gift_g_layer_3share;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v0_in, r0_in, v0_out, r0_out;
    logic [63:0] a0, b0, c0, x0, y0, z0;
    logic        v1_in, r1_in, v1_out, r1_out;
    logic [63:0] a1, b1, c1, x1, y1, z1;
    logic        v2_in, r2_in, v2_out, r2_out;
    logic [3:0]  a2, b2, c2, x2, y2, z2;

    gift_g_layer_3share #(.NSBOX(16), .OUT_REG(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(v0_in), .in_ready(r0_in),
        .in1(a0), .in2(b0), .in3(c0), .out_valid(v0_out), .out_ready(r0_out),
        .out1(x0), .out2(y0), .out3(z0));
    gift_g_layer_3share #(.NSBOX(16), .OUT_REG(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1_in), .in_ready(r1_in),
        .in1(a1), .in2(b1), .in3(c1), .out_valid(v1_out), .out_ready(r1_out),
        .out1(x1), .out2(y1), .out3(z1));
    gift_g_layer_3share #(.NSBOX(1), .OUT_REG(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(v2_in), .in_ready(r2_in),
        .in1(a2), .in2(b2), .in3(c2), .out_valid(v2_out), .out_ready(r2_out),
        .out1(x2), .out2(y2), .out3(z2));

    // Unmasked G: y0 = a^bc, y1 = d, y2 = b^ad, y3 = c^ab, tabulated by hand.
    logic [3:0] g_lut [16] = '{4'h0, 4'h1, 4'h4, 4'hD, 4'h8, 4'h9, 4'hD, 4'h4,
                               4'h2, 4'h7, 4'h6, 4'hB, 4'hA, 4'hF, 4'hF, 4'h2};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] g_ref(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = g_lut[x[4*i +: 4]];
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] xv, first1, ex;
        logic [63:0] q[$];
        logic [63:0] p1, p2, p3;
        logic        pv, pr, acc, saw_low;
        int          vary, sent, recv, first_acc, first_out;
        logic [3:0]  xp;

        rst = 1'b1;
        v0_in = 0; v1_in = 0; v2_in = 0;
        r0_out = 1; r1_out = 1; r2_out = 1;
        a0 = 0; b0 = 0; c0 = 0; a1 = 0; b1 = 0; c1 = 0; a2 = 0; b2 = 0; c2 = 0;
        repeat (2) @(negedge clk);
        check("rst_valid", {v0_out, v1_out, v2_out}, 0);
        check("rst_out0", x0 | y0 | z0, 0);
        check("rst_out1", x1 | y1 | z1, 0);
        check("rst_out2", x2 | y2 | z2, 0);
        check("rst_ready", {r0_in, r1_in, r2_in}, 3'b111);
        rst = 1'b0;

        // Latency 1 and per-X correctness on the 16-slice combinational-output instance.
        for (int x = 0; x < 16; x++) begin
            xv = {16{4'(x)}};
            a0 = rnd64(); b0 = rnd64(); c0 = a0 ^ b0 ^ xv;
            v0_in = 1;
            check("lat_in_ready", r0_in, 1);
            @(negedge clk);
            v0_in = 0;
            check("lat_valid", v0_out, 1);
            check("lat_g", x0 ^ y0 ^ z0, g_ref(xv));
            check("lat_bit1", (x0[1] ^ y0[1] ^ z0[1]), xv[3]);
            @(negedge clk);
            check("lat_single", v0_out, 0);
        end

        // Mask independence: fixed X=3, fresh masks every batch.
        vary = 0;
        xv = {16{4'h3}};
        for (int t = 0; t <= 100; t++) begin
            if (t > 0) begin
                check("mask_g", {v0_out, x0 ^ y0 ^ z0}, {1'b1, g_ref(xv)});
                if (t == 1) first1 = x0;
                else if (x0 != first1) vary++;
            end
            if (t < 100) begin
                a0 = rnd64(); b0 = rnd64(); c0 = a0 ^ b0 ^ xv; v0_in = 1;
            end else v0_in = 0;
            @(negedge clk);
        end
        check("mask_vary", (vary > 0), 1);

        // Full throughput with random data.
        q.delete();
        for (int t = 0; t <= 20; t++) begin
            if (t > 0) begin
                ex = q.pop_front();
                check("tput_out", {v0_out, x0 ^ y0 ^ z0}, {1'b1, ex});
            end
            if (t < 20) begin
                xv = rnd64();
                a0 = rnd64(); b0 = rnd64(); c0 = a0 ^ b0 ^ xv; v0_in = 1;
                check("tput_ready", r0_in, 1);
                q.push_back(g_ref(xv));
            end else v0_in = 0;
            @(negedge clk);
        end

        // Reset while a batch is in flight, with a competing in_valid.
        xv = rnd64(); a0 = rnd64(); b0 = rnd64(); c0 = a0 ^ b0 ^ xv; v0_in = 1;
        @(negedge clk);
        check("rmid_accepted", v0_out, 1);
        rst = 1; a0 = rnd64(); b0 = rnd64(); c0 = rnd64();
        @(negedge clk);
        check("rmid_valid", v0_out, 0);
        check("rmid_out", x0 | y0 | z0, 0);
        check("rmid_ready", r0_in, 1);
        rst = 0; v0_in = 0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("rmid_gone", v0_out, 0);
        end

        // Backpressure on the two-stage instance.
        q.delete();
        sent = 0; recv = 0; first_acc = -1; first_out = -1;
        pv = 0; pr = 1; acc = 0; saw_low = 0; p1 = 0; p2 = 0; p3 = 0;
        for (int c = 0; c < 40 && recv < 5; c++) begin
            r1_out = !(c >= 3 && c <= 6);
            if (pv && !pr) begin
                check("bp_hold1", x1, p1);
                check("bp_hold2", y1, p2);
                check("bp_hold3", z1, p3);
            end
            if (v1_out && r1_out) begin
                if (first_out < 0) first_out = c;
                if (q.size() == 0) check("bp_dup", 1, 0);
                else check("bp_data", x1 ^ y1 ^ z1, q.pop_front());
                recv++;
            end
            pv = v1_out; pr = r1_out; p1 = x1; p2 = y1; p3 = z1;
            if (acc) v1_in = 0;
            if (!v1_in && sent < 5) begin
                xv = rnd64(); a1 = rnd64(); b1 = rnd64(); c1 = a1 ^ b1 ^ xv;
                v1_in = 1;
            end
            #1;
            if (!r1_in) saw_low = 1;
            acc = v1_in && r1_in;
            if (acc) begin
                if (first_acc < 0) first_acc = c;
                q.push_back(g_ref(xv));
                sent++;
            end
            @(negedge clk);
        end
        v1_in = 0; r1_out = 1;
        check("bp_count", recv, 5);
        check("bp_left", q.size(), 0);
        check("bp_ready_low", saw_low, 1);
        check("bp_latency", first_out - first_acc, 2);

        // Exhaustive share triples on the single-slice instance.
        xp = 0;
        for (int t = 0; t <= 4096; t++) begin
            if (t > 0) check("exh", {v2_out, x2 ^ y2 ^ z2}, {1'b1, g_lut[xp]});
            if (t < 4096) begin
                a2 = 4'(t); b2 = 4'(t >> 4); c2 = 4'(t >> 8);
                xp = a2 ^ b2 ^ c2;
                v2_in = 1;
            end else v2_in = 0;
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/gift_g_layer_3share.md
Name: gift_g_layer_3share

Overview:
- Parametrised successor to the single-nibble, 3-share, second-order, no-fresh-randomness GIFT G-stage.
- Applies the masked quadratic G function to NSBOX nibbles in parallel. Adds a valid/ready pipeline with backpressure, a synchronous reset, and an optional output compression register.
- Sits between the masked state register and the masked linear layer of the GIFT round datapath.
- Consumes no fresh randomness.

Parameters:
- NSBOX, 16, number of parallel 4-bit S-box slices (1..32).
- OUT_REG, 0, 0 = compression combinational after stage-1 register (latency 1); 1 = compressed shares registered (latency 2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input shares valid
- in_ready  out  1  block accepts input this cycle
- in1  in  4*NSBOX  share 1, nibble i at [4i+3:4i]
- in2  in  4*NSBOX  share 2
- in3  in  4*NSBOX  share 3
- out_valid  out  1  output shares valid
- out_ready  in  1  downstream accepts output
- out1  out  4*NSBOX  output share 1
- out2  out  4*NSBOX  output share 2
- out3  out  4*NSBOX  output share 3

Behaviour:
- Per slice i, inputs are a=bit0, b=bit1, c=bit2, d=bit3. Each bit is gathered as the 3-bit vector {in3,in2,in1}.
- Per slice i, the team's 27-output component-function block NF_CF_2 is instantiated.
- Stage 1 register (per slice): 27 CF outputs, plus the 3 shares of input bit 3, plus v1.
- Compression, per slice, share j in {1,2,3}, k = j-1:
  - bit0 = XOR of CF[3k..3k+2]
  - bit2 = XOR of CF[9+3k..9+3k+2]
  - bit3 = XOR of CF[18+3k..18+3k+2]
  - bit1 = registered share j of input bit 3 (linear wire, share-wise; never combined across shares)
- Compression inputs come only from registered values. No unregistered path exists from in* to out*.
- Unmasked correctness: out1^out2^out3 = G(in1^in2^in3) per nibble, with G as defined by the team golden model. Unmasked output bit1 equals unmasked input bit3.
- OUT_REG=0:
  - out* is driven by compression of the stage-1 registers; out_valid = v1.
  - Advance when in_ready = !v1 | out_ready.
- OUT_REG=1:
  - Stage 2 registers compressed shares plus v2; out* = stage-2 registers; out_valid = v2.
  - adv2 = !v2 | out_ready
  - in_ready = !v1 | adv2
  - Stage 1 moves to stage 2 when v1 & adv2.
- Input accepted when in_valid & in_ready. A stage loads only on advance. Stalled stages hold all data bits; they never load new data while stalled, so there is no data glitching into held shares.
- If a stage advances with no incoming valid, its valid bit clears. Its data registers may load (don't-care), but they are gated to hold when the upstream valid is 0, to reduce toggling.
- Throughput: 1 batch/cycle when out_ready=1.
- Simultaneous accept and emit on a full stage is allowed (pass-through, no bubble).
- Reset (rst=1 at edge): v1, v2 cleared; all CF, linear and stage-2 data registers cleared to 0. After reset: out1=out2=out3=0, out_valid=0, in_ready=1.
- Reset mid-operation: in-flight batches are dropped and no partial output is emitted. rst overrides a simultaneous in_valid.
- out_ready is ignored while out_valid=0. in_valid=0 never changes stored data.

Test Plan:
- Latency, OUT_REG=0, NSBOX=16: after rst, drive one batch with in1=random, in2=random, in3=in1^in2^X for all 16 X in 0..F; out_ready=1. Required: out_valid high exactly 1 cycle after accept; per nibble, out1^out2^out3 = G(X) from the golden model; bit1 = X[3] (e.g. X=8 gives bit1=1, X=7 gives bit1=0).
- Mask independence: same X=0x3 in every nibble, 100 batches with fresh random in1/in2. Required: the unmasked output is identical for all batches; the individual shares vary.
- Backpressure, OUT_REG=1: stream 5 batches, out_ready=0 for cycles 3–6. Required:
  - in_ready drops once both stages are full.
  - out* is stable while stalled.
  - All 5 outputs arrive in order with no loss or duplication.
  - Latency is 2 cycles with no stall.
- Full throughput: in_valid=1, out_ready=1 for 20 cycles. Required: 20 consecutive out_valid cycles after latency; in_ready stays 1.
- Reset mid-flight: accept a batch, then assert rst in the next cycle together with in_valid=1. Required: out_valid=0, out*=0 on the following cycle; the batch never appears; in_ready=1.
- NSBOX=1: exhaustive sweep of all 4096 share triples. Required: the unmasked output equals G for every triple.
